// File: rtl/game_pkg.sv
// Shared state codes and datapath widths for the game sequencer slice.
package game_pkg;
  localparam int SCORE_W = 16;
  localparam int LIVES_W = 3;
  localparam int DIV_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUN       = 3'd2,
    ST_HIT       = 3'd3,
    ST_OVER      = 3'd4
  } state_t;
endpackage

// File: rtl/bcd_counter_4d.sv
// Four-digit BCD up-counter that holds at 9999; clear takes priority over increment.
module bcd_counter_4d
  import game_pkg::*;
(
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iClear,
  input  logic               iInc,
  output logic [SCORE_W-1:0] oValue
);

  function automatic logic [SCORE_W-1:0] bcdInc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      return v;
    end
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge iClk) begin
    if (iReset || iClear) begin
      oValue <= '0;
    end else if (iInc) begin
      oValue <= bcdInc(oValue);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Master game controller: phase FSM, lives, BCD score and score-driven step speedup.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int HIT_TICKS       = 4,
  parameter int START_DIV       = 4,
  parameter int MIN_DIV         = 1,
  parameter int SPEEDUP_POINTS  = 5
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iTick,
  input  logic                iStart,
  input  logic                iCollision,
  input  logic                iScorePulse,
  output logic                oEnableLFSR,
  output logic                oPintar,
  output logic                oResetPintar,
  output logic                oStep,
  output logic                oBlink,
  output logic                oGameOver,
  output logic [2:0]          oState,
  output logic [LIVES_W-1:0]  oLives,
  output logic [3:0]          oCountdown,
  output logic [SCORE_W-1:0]  oScore
);

  state_t             state;
  logic               startHist;
  logic [3:0]         countdown;
  logic [3:0]         hitCnt;
  logic [3:0]         pointsCnt;
  logic [LIVES_W-1:0] lives;
  logic [DIV_W-1:0]   divider;
  logic [DIV_W-1:0]   activeDiv;
  logic [DIV_W-1:0]   stepCnt;
  logic [DIV_W-1:0]   divNext;
  logic [2:0]         ctrl;
  logic               blink;
  logic               resetPintar;
  logic               step;
  logic               startEdge;
  logic               scoreClear;
  logic               scoreInc;
  logic               pointWrap;

  // {gameOver, enableLFSR, pintar} for the phase being entered
  function automatic logic [2:0] ctrlFor(input state_t s);
    case (s)
      ST_COUNTDOWN: return 3'b011;
      ST_RUN:       return 3'b011;
      ST_HIT:       return 3'b001;
      ST_OVER:      return 3'b101;
      default:      return 3'b000;
    endcase
  endfunction

  assign startEdge  = iStart & ~startHist;
  assign scoreClear = startEdge & ((state == ST_IDLE) | (state == ST_OVER));
  assign scoreInc   = (state == ST_RUN) & iScorePulse & ~iCollision;
  assign pointWrap  = scoreInc & (pointsCnt == 4'(SPEEDUP_POINTS - 1));
  assign divNext    = (pointWrap && divider > DIV_W'(MIN_DIV)) ? divider - DIV_W'(1) : divider;

  bcd_counter_4d scoreCounter (
    .iClk   (iClk),
    .iReset (iReset),
    .iClear (scoreClear),
    .iInc   (scoreInc),
    .oValue (oScore)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state       <= ST_IDLE;
      startHist   <= 1'b1;
      countdown   <= '0;
      hitCnt      <= '0;
      pointsCnt   <= '0;
      lives       <= LIVES_W'(LIVES);
      divider     <= DIV_W'(START_DIV);
      activeDiv   <= DIV_W'(START_DIV);
      stepCnt     <= '0;
      blink       <= 1'b0;
      resetPintar <= 1'b0;
      step        <= 1'b0;
      ctrl        <= 3'b000;
    end else begin
      startHist   <= iStart;
      resetPintar <= 1'b0;
      step        <= 1'b0;
      divider     <= divNext;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (startEdge) begin
            state       <= ST_COUNTDOWN;
            ctrl        <= ctrlFor(ST_COUNTDOWN);
            countdown   <= 4'(COUNTDOWN_TICKS);
            lives       <= LIVES_W'(LIVES);
            divider     <= DIV_W'(START_DIV);
            pointsCnt   <= '0;
            resetPintar <= 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (iTick) begin
            countdown <= countdown - 4'd1;
            if (countdown == 4'd1) begin
              state     <= ST_RUN;
              ctrl      <= ctrlFor(ST_RUN);
              stepCnt   <= '0;
              activeDiv <= divider;
            end
          end
        end
        ST_RUN: begin
          // A collision pre-empts both the point and any step due this cycle
          if (iCollision) begin
            if (lives == LIVES_W'(1)) begin
              state <= ST_OVER;
              ctrl  <= ctrlFor(ST_OVER);
              lives <= '0;
            end else begin
              state  <= ST_HIT;
              ctrl   <= ctrlFor(ST_HIT);
              lives  <= lives - LIVES_W'(1);
              blink  <= 1'b1;
              hitCnt <= '0;
            end
          end else begin
            if (scoreInc) begin
              pointsCnt <= pointWrap ? 4'd0 : pointsCnt + 4'd1;
            end
            if (iTick) begin
              // The period only picks up a new divider when it restarts
              if (stepCnt == activeDiv - DIV_W'(1)) begin
                step      <= 1'b1;
                stepCnt   <= '0;
                activeDiv <= divNext;
              end else begin
                stepCnt <= stepCnt + DIV_W'(1);
              end
            end
          end
        end
        ST_HIT: begin
          if (iTick) begin
            if (hitCnt == 4'(HIT_TICKS - 1)) begin
              state       <= ST_COUNTDOWN;
              ctrl        <= ctrlFor(ST_COUNTDOWN);
              countdown   <= 4'(COUNTDOWN_TICKS);
              blink       <= 1'b0;
              resetPintar <= 1'b1;
            end else begin
              hitCnt <= hitCnt + 4'd1;
              blink  <= ~blink;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ctrl  <= ctrlFor(ST_IDLE);
          blink <= 1'b0;
        end
      endcase
    end
  end

  assign oState       = state;
  assign oLives       = lives;
  assign oCountdown   = countdown;
  assign oBlink       = blink;
  assign oResetPintar = resetPintar;
  assign oStep        = step;
  assign oGameOver    = ctrl[2];
  assign oEnableLFSR  = ctrl[1];
  assign oPintar      = ctrl[0];

endmodule
